// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the MEM-stage data-memory responder: access sizes,
// FSM states and the captured request record.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        RespErr;
  logic        Stall;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
    input  ReqReady, RespValid, RespRData, RespErr, Stall
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
    output ReqReady, RespValid, RespRData, RespErr, Stall
  );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Combinational lane logic: load extract/extend and store read-modify-write
// merge for little-endian byte/half/word accesses.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_old[7:0];
      2'd1: w_byte = i_old[15:8];
      2'd2: w_byte = i_old[23:16];
      default: w_byte = i_old[31:24];
    endcase
    // Half lane uses addr[1] only; addr[0] is ignored when misaligned.
    w_half = i_addr_lo[1] ? i_old[31:16] : i_old[15:0];
  end

  always_comb begin
    o_rdata = i_old;
    case (i_size)
      SIZE_BYTE: o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      SIZE_HALF: o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      default:   o_rdata = i_old;
    endcase
  end

  always_comb begin
    o_wword = i_old;
    case (i_size)
      SIZE_BYTE: begin
        case (i_addr_lo)
          2'd0: o_wword[7:0]   = i_wdata[7:0];
          2'd1: o_wword[15:8]  = i_wdata[7:0];
          2'd2: o_wword[23:16] = i_wdata[7:0];
          default: o_wword[31:24] = i_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (i_addr_lo[1]) o_wword[31:16] = i_wdata[15:0];
        else              o_wword[15:0]  = i_wdata[15:0];
      end
      default: o_wword = i_wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder for the MIPS MEM stage.
// Optional macro MISALIGN_CHECK_EN: flag misaligned half/word accesses as errors.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  mem_req_t    r_req;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  mem_req_t    w_in, w_cur;
  logic [AW-1:0] w_idx;
  logic        w_oor, w_mis, w_err;
  logic [31:0] w_old, w_load, w_wword;

  always_comb begin
    w_in = '{write: bus.ReqWrite, size: bus.ReqSize, sgn: bus.ReqSigned,
             addr: bus.ReqAddr, wdata: bus.ReqWData};
    // In IDLE the live request is evaluated so a zero-wait access can
    // register its response on the accepting edge.
    w_cur = (r_state == ST_IDLE) ? w_in : r_req;
  end

  assign w_idx = w_cur.addr[AW+1:2];
  assign w_oor = (w_cur.addr >> (AW + 2)) != 32'd0;
`ifdef MISALIGN_CHECK_EN
  assign w_mis = ((w_cur.size == SIZE_HALF) && w_cur.addr[0]) ||
                 (w_cur.size[1] && (w_cur.addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif
  assign w_err = w_oor | w_mis;
  assign w_old = r_mem[w_idx];

  mem_lane_align u_align (
    .i_old     (w_old),
    .i_wdata   (w_cur.wdata),
    .i_addr_lo (w_cur.addr[1:0]),
    .i_size    (w_cur.size),
    .i_signed  (w_cur.sgn),
    .o_rdata   (w_load),
    .o_wword   (w_wword)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.ReqValid) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && bus.ReqValid) begin
        r_req <= w_in;
        r_cnt <= 4'(WAIT_CYCLES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_next == ST_RESP && r_state != ST_RESP) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_cur.write) ? 32'd0 : w_load;
      end
    end
  end

  // Store commits leaving RESP; a reset in that cycle drops it.
  always_ff @(posedge Clk) begin
    if (!Rst && r_state == ST_RESP && r_req.write && !r_err)
      r_mem[w_idx] <= w_wword;
  end

  assign bus.ReqReady  = (r_state == ST_IDLE);
  assign bus.RespValid = (r_state == ST_RESP);
  assign bus.RespRData = r_rdata;
  assign bus.RespErr   = r_err;
  assign bus.Stall     = bus.ReqValid & ~bus.RespValid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a queue/array reference model.
module tb_data_mem_responder;
  import mips_mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;
  localparam int AW    = 10;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    mem_req_t req;
    int       due;
  } pend_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        rst_seen = 1'b0;
  pend_t       q[$];
  logic [31:0] mmem [DEPTH];
  int          resp_cnt = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Response rule: {err, rdata}
  function automatic logic [32:0] model_resp(input mem_req_t r);
    logic err;
    logic [31:0] w, d;
    int k;
    err = (r.addr >> (AW + 2)) != 32'd0;
`ifdef MISALIGN_CHECK_EN
    if (r.size == SIZE_HALF && r.addr[0]) err = 1'b1;
    if (r.size[1] && r.addr[1:0] != 2'b00) err = 1'b1;
`endif
    d = 32'd0;
    if (!err && !r.write) begin
      w = mmem[int'(r.addr[AW+1:2])];
      if (r.size == SIZE_BYTE) begin
        k = int'(r.addr[1:0]);
        d = (w >> (8 * k)) & 32'hFF;
        if (r.sgn && d[7]) d = d | 32'hFFFFFF00;
      end else if (r.size == SIZE_HALF) begin
        k = int'(r.addr[1]);
        d = (w >> (16 * k)) & 32'hFFFF;
        if (r.sgn && d[15]) d = d | 32'hFFFF0000;
      end else begin
        d = w;
      end
    end
    return {err, d};
  endfunction

  task automatic model_store(input mem_req_t r);
    int idx, k;
    logic [31:0] mask, data;
    idx = int'(r.addr[AW+1:2]);
    if (r.size == SIZE_BYTE) begin
      k = int'(r.addr[1:0]);
      mask = 32'hFF << (8 * k);
      data = (r.wdata & 32'hFF) << (8 * k);
    end else if (r.size == SIZE_HALF) begin
      k = int'(r.addr[1]);
      mask = 32'hFFFF << (16 * k);
      data = (r.wdata & 32'hFFFF) << (16 * k);
    end else begin
      mask = 32'hFFFFFFFF;
      data = r.wdata;
    end
    mmem[idx] = (mmem[idx] & ~mask) | data;
  endtask

  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    rst_seen <= Rst;
  end

  // Per-cycle compare against the model
  always @(negedge Clk) begin : cmp
    bit ev;
    logic [32:0] e;
    if (cyc > 0) begin
      if (rst_seen) begin
        q.delete();
        chk("rst_ready", {31'd0, bus.ReqReady}, 32'd1);
        chk("rst_valid", {31'd0, bus.RespValid}, 32'd0);
        chk("rst_rdata", bus.RespRData, 32'd0);
        chk("rst_err", {31'd0, bus.RespErr}, 32'd0);
      end else begin
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("ready", {31'd0, bus.ReqReady}, {31'd0, q.size() == 0});
        chk("resp_valid", {31'd0, bus.RespValid}, {31'd0, ev});
        chk("stall", {31'd0, bus.Stall}, {31'd0, bus.ReqValid && !ev});
        if (ev) begin
          e = model_resp(q[0].req);
          chk("rdata", bus.RespRData, e[31:0]);
          chk("err", {31'd0, bus.RespErr}, {31'd0, e[32]});
          if (q[0].req.write && !e[32]) model_store(q[0].req);
          last_rdata = bus.RespRData;
          last_err   = bus.RespErr;
          last_cyc   = cyc;
          resp_cnt++;
          void'(q.pop_front());
        end
      end
    end
  end

  // abort: assert Rst during the first wait cycle instead of waiting for the response
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit drop, input bit abort,
                        output logic [31:0] rd, output logic er, output int lat);
    int n, acc, rc0;
    mem_req_t r;
    pend_t p;
    rd = 32'd0; er = 1'b0; lat = 0;
    r = '{write: wr, size: sz, sgn: sg, addr: a, wdata: wd};
    @(negedge Clk); #1;
    bus.ReqValid = 1'b1; bus.ReqWrite = wr; bus.ReqSize = sz;
    bus.ReqSigned = sg; bus.ReqAddr = a; bus.ReqWData = wd;
    n = 0;
    while (!bus.ReqReady && n < 50) begin @(negedge Clk); #1; n++; end
    if (n >= 50) begin fail_now("accept_timeout"); bus.ReqValid = 1'b0; return; end
    rc0 = resp_cnt;
    @(posedge Clk); #1;
    acc = cyc;
    p.req = r; p.due = acc + WAITC;
    q.push_back(p);
    if (abort) begin
      @(negedge Clk); #1;
      Rst = 1'b1; bus.ReqValid = 1'b0;
      @(negedge Clk); #1;
      Rst = 1'b0;
      chk("abort_no_resp", resp_cnt, rc0);
      return;
    end
    n = 0;
    while (resp_cnt == rc0 && n < 50) begin
      @(negedge Clk); #1;
      if (resp_cnt == rc0 && drop && $urandom_range(0, 1) == 1) bus.ReqValid = 1'b0;
      n++;
    end
    bus.ReqValid = 1'b0;
    if (resp_cnt == rc0) begin fail_now("resp_timeout"); return; end
    rd = last_rdata; er = last_err; lat = last_cyc - acc + 1;
  endtask

  initial begin : main
    logic [31:0] rd, a, wd;
    logic er;
    int lat;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = SIZE_WORD;
    bus.ReqSigned = 1'b0; bus.ReqAddr = 32'd0; bus.ReqWData = 32'd0;
    repeat (3) @(negedge Clk);
    #1 Rst = 1'b0;

    for (int i = 0; i < 32; i++)
      do_req(1'b1, SIZE_WORD, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b0, rd, er, lat);
    do_req(1'b1, SIZE_WORD, 1'b0, 32'((DEPTH - 1) * 4), $urandom, 1'b0, 1'b0, rd, er, lat);

    do_req(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, rd, er, lat);
    chk("sw_latency", lat, WAITC + 1);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);
    chk("lw_latency", lat, WAITC + 1);

    do_req(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h0000007F, 1'b0, 1'b0, rd, er, lat);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("sb_merge", rd, 32'hDEAD7FEF);
    do_req(1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFFDE);
    do_req(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("lbu", rd, 32'h000000DE);
    do_req(1'b0, SIZE_HALF, 1'b1, 32'h12, 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFFDEAD);

    do_req(1'b1, SIZE_WORD, 1'b0, 32'h0, 32'hA5A55A5A, 1'b0, 1'b0, rd, er, lat);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'(DEPTH * 4), 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("oor_lw_err", {31'd0, er}, 32'd1);
    chk("oor_lw_rdata", rd, 32'd0);
    do_req(1'b1, SIZE_WORD, 1'b0, 32'(DEPTH * 4), 32'hFFFFFFFF, 1'b0, 1'b0, rd, er, lat);
    chk("oor_sw_err", {31'd0, er}, 32'd1);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("oor_word0_kept", rd, 32'hA5A55A5A);

    do_req(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h11112222, 1'b0, 1'b0, rd, er, lat);
    do_req(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h12345678, 1'b0, 1'b1, rd, er, lat);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, rd, er, lat);
    chk("rst_store_dropped", rd, 32'h11112222);

    do_req(1'b0, SIZE_WORD, 1'b0, 32'h12, 32'd0, 1'b0, 1'b0, rd, er, lat);
`ifdef MISALIGN_CHECK_EN
    chk("misalign_err", {31'd0, er}, 32'd1);
    chk("misalign_rdata", rd, 32'd0);
`else
    chk("misalign_err", {31'd0, er}, 32'd0);
    chk("misalign_rdata", rd, 32'hDEAD7FEF);
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) a = 32'((DEPTH - 1) * 4);
      else a = 32'($urandom_range(0, 31) * 4);
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
      wd = $urandom;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, wd, 1'($urandom_range(0, 1)), 1'b0, rd, er, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
    end

    repeat (4) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
